// File: rtl/muldiv_pkg.sv
// Shared opcode and state encodings for the multi-cycle multiply/divide unit.
package muldiv_pkg;

    localparam int unsigned MD_OP_W = 4;

    typedef enum logic [MD_OP_W-1:0] {
        MD_MULT  = 4'd0,
        MD_MULTU = 4'd1,
        MD_MADD  = 4'd2,
        MD_MADDU = 4'd3,
        MD_MSUB  = 4'd4,
        MD_MSUBU = 4'd5,
        MD_DIV   = 4'd6,
        MD_DIVU  = 4'd7,
        MD_MTHI  = 4'd8,
        MD_MTLO  = 4'd9
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIX  = 2'd3
    } md_state_e;

endpackage

// File: rtl/div_iter.sv
// One restoring radix-2 division step on unsigned magnitudes (combinational).
module div_iter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] dvs,
    output logic [WIDTH-1:0] rem_nxt,
    output logic [WIDTH-1:0] quo_nxt
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    // rem < dvs always holds, so the trial difference fits and its MSB is the borrow
    always_comb begin
        shifted = {rem, quo[WIDTH-1]};
        diff    = shifted - {1'b0, dvs};
        if (!diff[WIDTH]) begin
            rem_nxt = diff[WIDTH-1:0];
            quo_nxt = {quo[WIDTH-2:0], 1'b1};
        end else begin
            rem_nxt = shifted[WIDTH-1:0];
            quo_nxt = {quo[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit owning the architectural Hi/Lo pair.
module muldiv_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    import muldiv_pkg::*;

    localparam int unsigned PW    = 2 * WIDTH;
    localparam int unsigned CNT_W = $clog2(WIDTH);

    md_state_e            state;
    logic [MD_OP_W-1:0]   op_q;
    logic [WIDTH-1:0]     a_q;
    logic [WIDTH-1:0]     b_q;
    logic [WIDTH-1:0]     rem_q;
    logic [WIDTH-1:0]     quo_q;
    logic                 neg_q;
    logic                 sa_q;
    logic                 dz_q;
    logic [CNT_W-1:0]     cnt_q;

    logic [WIDTH-1:0]     rem_nxt;
    logic [WIDTH-1:0]     quo_nxt;

    logic                 in_sa;
    logic                 in_sb;
    logic [WIDTH-1:0]     in_mag_a;
    logic [WIDTH-1:0]     in_mag_b;

    logic                 mul_signed;
    logic [PW-1:0]        a_ext;
    logic [PW-1:0]        b_ext;
    logic [PW-1:0]        prod;
    logic [PW-1:0]        mul_res;

    assign busy = (state != ST_IDLE);

    div_iter #(.WIDTH(WIDTH)) u_div_iter (
        .rem     (rem_q),
        .quo     (quo_q),
        .dvs     (b_q),
        .rem_nxt (rem_nxt),
        .quo_nxt (quo_nxt)
    );

    // Divide operand signs and magnitudes at issue; even divide opcode is signed
    always_comb begin
        in_sa    = ~op[0] & a[WIDTH-1];
        in_sb    = ~op[0] & b[WIDTH-1];
        in_mag_a = in_sa ? (WIDTH'(0) - a) : a;
        in_mag_b = in_sb ? (WIDTH'(0) - b) : b;
    end

    // Product and accumulate, wrapping modulo 2^(2*WIDTH)
    always_comb begin
        mul_signed = ~op_q[0];
        a_ext      = mul_signed ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
        b_ext      = mul_signed ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
        prod       = a_ext * b_ext;
        case (op_q)
            MD_MADD, MD_MADDU: mul_res = {hi, lo} + prod;
            MD_MSUB, MD_MSUBU: mul_res = {hi, lo} - prod;
            default:           mul_res = prod;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            neg_q    <= 1'b0;
            sa_q     <= 1'b0;
            dz_q     <= 1'b0;
            cnt_q    <= '0;
            hi       <= '0;
            lo       <= '0;
            done     <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            done     <= 1'b0;
            div_zero <= 1'b0;
            if (flush) begin
                state <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start) begin
                            case (op)
                                MD_MULT, MD_MULTU, MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU: begin
                                    op_q  <= op;
                                    a_q   <= a;
                                    b_q   <= b;
                                    state <= ST_MUL;
                                end
                                MD_DIV, MD_DIVU: begin
                                    op_q  <= op;
                                    a_q   <= a;
                                    b_q   <= in_mag_b;
                                    rem_q <= '0;
                                    quo_q <= in_mag_a;
                                    sa_q  <= in_sa;
                                    neg_q <= in_sa ^ in_sb;
                                    cnt_q <= CNT_W'(WIDTH - 1);
                                    dz_q  <= (b == '0);
                                    state <= (b == '0) ? ST_FIX : ST_DIV;
                                end
                                MD_MTHI: begin
                                    hi   <= a;
                                    done <= 1'b1;
                                end
                                MD_MTLO: begin
                                    lo   <= a;
                                    done <= 1'b1;
                                end
                                default: ;
                            endcase
                        end
                    end
                    ST_MUL: begin
                        {hi, lo} <= mul_res;
                        done     <= 1'b1;
                        state    <= ST_IDLE;
                    end
                    ST_DIV: begin
                        rem_q <= rem_nxt;
                        quo_q <= quo_nxt;
                        if (cnt_q == '0) begin
                            state <= ST_FIX;
                        end else begin
                            cnt_q <= cnt_q - CNT_W'(1);
                        end
                    end
                    ST_FIX: begin
                        // Signs are pre-masked for DIVU, so one path covers both
                        if (dz_q) begin
                            lo       <= '1;
                            hi       <= a_q;
                            div_zero <= 1'b1;
                        end else begin
                            lo <= neg_q ? (WIDTH'(0) - quo_q) : quo_q;
                            hi <= sa_q ? (WIDTH'(0) - rem_q) : rem_q;
                        end
                        done  <= 1'b1;
                        state <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: sequential vector table plus abort/handshake sequences.
module tb_muldiv_unit;

    localparam int unsigned W     = 32;
    localparam int          L_MUL = 1;
    localparam int          L_DIV = W + 1;
    localparam int          L_MT  = 0;
    localparam int          L_DZ  = 1;
    localparam int          NVEC  = 18;

    logic         clk;
    logic         rst;
    logic         start;
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         flush;
    logic         busy;
    logic         done;
    logic         div_zero;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int total;
    int bad;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] ehi;
        logic [31:0] elo;
        logic        edz;
        int          lat;
    } vec_t;

    vec_t vecs [NVEC];

    muldiv_unit #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .flush    (flush),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .hi       (hi),
        .lo       (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic run_op(input vec_t v, input int idx);
        int    k;
        int    drops;
        string tag;
        tag = $sformatf("v%0d", idx);
        @(negedge clk);
        start = 1'b1;
        op    = v.op;
        a     = v.a;
        b     = v.b;
        @(posedge clk);
        #1;
        start = 1'b0;
        k     = 0;
        drops = 0;
        while (!done && k < 200) begin
            if (!busy) drops++;
            @(posedge clk);
            #1;
            k++;
        end
        check({tag, "_lat"}, 32'(k), 32'(v.lat));
        check({tag, "_busy_hold"}, 32'(drops), 32'd0);
        check({tag, "_busy_done"}, 32'(busy), 32'd0);
        check({tag, "_hi"}, hi, v.ehi);
        check({tag, "_lo"}, lo, v.elo);
        check({tag, "_dz"}, 32'(div_zero), 32'(v.edz));
    endtask

    initial begin
        int k;
        int ndone;

        total = 0;
        bad   = 0;
        rst   = 1'b1;
        start = 1'b0;
        op    = 4'd0;
        a     = '0;
        b     = '0;
        flush = 1'b0;

        vecs[0]  = '{4'd0, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, 1'b0, L_MUL};
        vecs[1]  = '{4'd9, 32'hFFFFFFFF, 32'd0,        32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, L_MT};
        vecs[2]  = '{4'd8, 32'h00000000, 32'd0,        32'h00000000, 32'hFFFFFFFF, 1'b0, L_MT};
        vecs[3]  = '{4'd3, 32'd1,        32'd1,        32'h00000001, 32'h00000000, 1'b0, L_MUL};
        vecs[4]  = '{4'd8, 32'd0,        32'd0,        32'h00000000, 32'h00000000, 1'b0, L_MT};
        vecs[5]  = '{4'd9, 32'd0,        32'd0,        32'h00000000, 32'h00000000, 1'b0, L_MT};
        vecs[6]  = '{4'd4, 32'd2,        32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, 1'b0, L_MUL};
        vecs[7]  = '{4'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, L_MUL};
        vecs[8]  = '{4'd2, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, L_MUL};
        vecs[9]  = '{4'd5, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFD, 32'h00000000, 1'b0, L_MUL};
        vecs[10] = '{4'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, L_DIV};
        vecs[11] = '{4'd7, 32'd5,        32'd0,        32'h00000005, 32'hFFFFFFFF, 1'b1, L_DZ};
        vecs[12] = '{4'd6, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, L_DIV};
        vecs[13] = '{4'd7, 32'd100,      32'd7,        32'h00000002, 32'h0000000E, 1'b0, L_DIV};
        vecs[14] = '{4'd6, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, L_DIV};
        vecs[15] = '{4'd6, 32'd0,        32'd0,        32'h00000000, 32'hFFFFFFFF, 1'b1, L_DZ};
        vecs[16] = '{4'd7, 32'hFFFFFFFF, 32'd1,        32'h00000000, 32'hFFFFFFFF, 1'b0, L_DIV};
        vecs[17] = '{4'd1, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 1'b0, L_MUL};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_dz", 32'(div_zero), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < NVEC; i++) run_op(vecs[i], i);

        // Reserved opcode: nothing happens; also confirms done dropped after one cycle
        @(negedge clk);
        start = 1'b1;
        op    = 4'd12;
        a     = 32'h12345678;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("ign_busy", 32'(busy), 32'd0);
        check("ign_done0", 32'(done), 32'd0);
        @(posedge clk);
        #1;
        check("ign_done1", 32'(done), 32'd0);
        check("ign_hi", hi, 32'h1);
        check("ign_lo", lo, 32'h0);

        // Flush wins over start on the same edge
        @(negedge clk);
        flush = 1'b1;
        start = 1'b1;
        op    = 4'd9;
        a     = 32'h00001234;
        @(posedge clk);
        #1;
        flush = 1'b0;
        start = 1'b0;
        check("fls_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        check("fls_done", 32'(done), 32'd0);
        check("fls_lo", lo, 32'h0);

        // Flush during a divide
        @(negedge clk);
        start = 1'b1;
        op    = 4'd6;
        a     = 32'd100;
        b     = 32'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        check("fdiv_busy_pre", 32'(busy), 32'd1);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("fdiv_busy", 32'(busy), 32'd0);
        ndone = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        check("fdiv_nodone", 32'(ndone), 32'd0);
        check("fdiv_hi", hi, 32'h1);
        check("fdiv_lo", lo, 32'h0);

        // Start while busy is dropped
        @(negedge clk);
        start = 1'b1;
        op    = 4'd7;
        a     = 32'd100;
        b     = 32'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        k     = 0;
        repeat (4) begin
            @(posedge clk);
            #1;
            k++;
        end
        @(negedge clk);
        start = 1'b1;
        op    = 4'd9;
        a     = 32'h0000DEAD;
        @(posedge clk);
        #1;
        k++;
        start = 1'b0;
        while (!done && k < 200) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("sbusy_lat", 32'(k), 32'(L_DIV));
        check("sbusy_hi", hi, 32'h2);
        check("sbusy_lo", lo, 32'hE);
        @(posedge clk);
        #1;
        check("sbusy_no2nd", 32'(done), 32'd0);

        // Asynchronous reset mid-divide
        @(negedge clk);
        start = 1'b1;
        op    = 4'd6;
        a     = 32'hFFFFFFF9;
        b     = 32'd2;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("arst_hi", hi, 32'h0);
        check("arst_lo", lo, 32'h0);
        check("arst_busy", 32'(busy), 32'd0);
        #2;
        rst = 1'b0;
        ndone = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        check("arst_nodone", 32'(ndone), 32'd0);
        check("arst_idle", 32'(busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
